// File: rtl/next_pc_pkg.sv
// next_pc_pkg: branch-kind encodings and flag bit positions shared by the next-PC logic.
package next_pc_pkg;
  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BLTZ = 4'd2;
  localparam logic [3:0] BR_BZ   = 4'd3;
  localparam logic [3:0] BR_BNZ  = 4'd4;
  localparam logic [3:0] BR_BCY  = 4'd5;
  localparam logic [3:0] BR_BNCY = 4'd6;
  localparam logic [3:0] BR_BR   = 4'd7;
  localparam logic [3:0] BR_BL   = 4'd8;
  localparam logic [3:0] BR_RET  = 4'd9;
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
  parameter int W = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [PW:0] r_cnt;
  logic [PW-1:0] w_prev;
  // r_top is the next free slot, so when full it also addresses the oldest entry
  assign w_prev = r_top - PW'(1);
  assign dout = r_mem[w_prev];
  assign empty = r_cnt == '0;
  assign full = r_cnt == (PW+1)'(RAS_DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top <= '0;
      r_cnt <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= push & full;
      underflow <= pop & empty;
      if (push) begin
        r_mem[r_top] <= din;
        r_top <= r_top + PW'(1);
        if (!full) r_cnt <= r_cnt + (PW+1)'(1);
      end else if (pop && !empty) begin
        r_top <= w_prev;
        r_cnt <= r_cnt - (PW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: PC and flag registers with zero-bubble branch resolution and a return-address stack.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter int W = 32,
  parameter int PA_W = 26,
  parameter int RAS_DEPTH = 4,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic [3:0]      br_type,
  input  logic [W-1:0]    imm,
  input  logic [PA_W-1:0] pseudo_addr,
  input  logic [W-1:0]    reg_target,
  input  logic [2:0]      flags_in,
  input  logic            flags_we,
  output logic [W-1:0]    pc_out,
  output logic [W-1:0]    link_out,
  output logic            taken,
  output logic            ras_overflow,
  output logic            ras_underflow
);
  logic [W-1:0] r_pc, r_link, w_seq, w_cond, w_pseudo, w_tgt, w_ras_dout;
  logic [2:0] r_flags, w_eff;
  logic r_taken, w_take, w_push, w_pop, w_accept, w_ras_empty, w_ras_full;
  assign w_accept = instr_valid & ~stall;
  assign w_eff = flags_we ? flags_in : r_flags;
  assign w_seq = r_pc + W'(4);
  assign w_cond = r_pc + (imm << 2);
  generate
    if (PA_W + 2 == W) begin : g_pa_full
      assign w_pseudo = {pseudo_addr, 2'b00};
    end else begin : g_pa_hi
      assign w_pseudo = {r_pc[W-1:PA_W+2], pseudo_addr, 2'b00};
    end
  endgenerate
  always_comb begin
    w_tgt = w_seq;
    w_take = 1'b0;
    w_push = 1'b0;
    w_pop = 1'b0;
    case (br_type)
      BR_B:    begin w_tgt = w_pseudo; w_take = 1'b1; end
      BR_BLTZ: begin w_tgt = w_cond; w_take = w_eff[FLG_N]; end
      BR_BZ:   begin w_tgt = w_cond; w_take = w_eff[FLG_Z]; end
      BR_BNZ:  begin w_tgt = w_cond; w_take = ~w_eff[FLG_Z]; end
      BR_BCY:  begin w_tgt = w_pseudo; w_take = w_eff[FLG_C]; end
      BR_BNCY: begin w_tgt = w_pseudo; w_take = ~w_eff[FLG_C]; end
      BR_BR:   begin w_tgt = reg_target; w_take = 1'b1; end
      BR_BL:   begin w_tgt = w_pseudo; w_take = 1'b1; w_push = 1'b1; end
      BR_RET:  begin w_tgt = w_ras_dout; w_take = ~w_ras_empty; w_pop = 1'b1; end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_link <= '0;
      r_taken <= 1'b0;
      r_flags <= '0;
    end else begin
      if (flags_we && !stall) r_flags <= flags_in;
      r_taken <= w_accept & w_take;
      if (w_accept) r_pc <= w_take ? w_tgt : w_seq;
      if (w_accept && w_push) r_link <= w_seq;
    end
  end
  return_addr_stack #(.W(W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(w_accept & w_push),
    .pop(w_accept & w_pop),
    .din(w_seq),
    .dout(w_ras_dout),
    .empty(w_ras_empty),
    .full(w_ras_full),
    .overflow(ras_overflow),
    .underflow(ras_underflow)
  );
  assign pc_out = r_pc;
  assign link_out = r_link;
  assign taken = r_taken;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and randomized checks of next_pc_unit against a queue-based reference model.
module tb_next_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, instr_valid, flags_we;
  logic [3:0] br_type;
  logic [31:0] imm, reg_target;
  logic [25:0] pseudo_addr;
  logic [2:0] flags_in;
  logic [31:0] pc_out, link_out;
  logic taken, ras_overflow, ras_underflow;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_link;
  logic [2:0] m_fl;
  logic m_tk, m_ov, m_un;
  logic [31:0] m_ras[$];

  next_pc_unit #(.W(32), .PA_W(26), .RAS_DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .br_type(br_type),
    .imm(imm), .pseudo_addr(pseudo_addr), .reg_target(reg_target), .flags_in(flags_in),
    .flags_we(flags_we), .pc_out(pc_out), .link_out(link_out), .taken(taken),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic st, input logic [3:0] bt,
                      input logic [31:0] im, input logic [25:0] pa, input logic [31:0] rt,
                      input logic [2:0] fi, input logic fwe);
    logic [2:0] eff;
    logic [31:0] seq, cnd, pse, nx;
    rst = r; instr_valid = v; stall = st; br_type = bt; imm = im;
    pseudo_addr = pa; reg_target = rt; flags_in = fi; flags_we = fwe;
    if (r) begin
      m_pc = 32'h100; m_link = 0; m_tk = 0; m_fl = 0; m_ov = 0; m_un = 0;
      m_ras.delete();
    end else begin
      eff = fwe ? fi : m_fl;
      m_tk = 0; m_ov = 0; m_un = 0;
      if (v && !st) begin
        seq = m_pc + 32'd4;
        cnd = 32'(m_pc + $signed(im) * 4);
        pse = {m_pc[31:28], pa, 2'b00};
        nx = seq;
        case (bt)
          4'd1: begin nx = pse; m_tk = 1; end
          4'd2: if (eff[2]) begin nx = cnd; m_tk = 1; end
          4'd3: if (eff[0]) begin nx = cnd; m_tk = 1; end
          4'd4: if (!eff[0]) begin nx = cnd; m_tk = 1; end
          4'd5: if (eff[1]) begin nx = pse; m_tk = 1; end
          4'd6: if (!eff[1]) begin nx = pse; m_tk = 1; end
          4'd7: begin nx = rt; m_tk = 1; end
          4'd8: begin
            nx = pse; m_tk = 1; m_link = seq;
            if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_ov = 1; end
            m_ras.push_back(seq);
          end
          4'd9: if (m_ras.size() == 0) m_un = 1; else begin nx = m_ras.pop_back(); m_tk = 1; end
          default: ;
        endcase
        m_pc = nx;
      end
      if (fwe && !st) m_fl = fi;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] bt, input logic [31:0] im, input logic [25:0] pa,
                    input logic [31:0] rt);
    step(0, 1, 0, bt, im, pa, rt, 3'b000, 0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    if ({pc_out, link_out, taken, ras_overflow, ras_underflow} !== {32'h100, 32'h0, 3'b000}) begin
      failures++; $display("FAIL reset pc=%h link=%h tk=%b ov=%b un=%b", pc_out, link_out, taken, ras_overflow, ras_underflow);
    end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      op(4'd0, 0, 0, 0);
      if (pc_out !== 32'h100 + 32'(i * 4) || taken !== 1'b0) begin
        failures++; $display("FAIL seq_run%0d pc=%h tk=%b want pc=%h tk=0", i, pc_out, taken, 32'h100 + 32'(i * 4));
      end
      checks++;
    end
  endtask

  task automatic test_cond;
    op(4'd7, 0, 0, 32'h200);
    step(0, 1, 0, 4'd3, 32'hFFFF_FFFE, 0, 0, 3'b001, 1);
    if (pc_out !== 32'h1F8 || taken !== 1'b1) begin
      failures++; $display("FAIL bz_taken pc=%h tk=%b want 1f8/1", pc_out, taken);
    end
    checks++;
    op(4'd7, 0, 0, 32'h200);
    step(0, 1, 0, 4'd3, 32'hFFFF_FFFE, 0, 0, 3'b000, 1);
    if (pc_out !== 32'h204 || taken !== 1'b0) begin
      failures++; $display("FAIL bz_not_taken pc=%h tk=%b want 204/0", pc_out, taken);
    end
    checks++;
  endtask

  task automatic test_pseudo;
    op(4'd7, 0, 0, 32'hA000_0010);
    op(4'd1, 0, 26'h40, 0);
    if (pc_out !== 32'hA000_0100 || taken !== 1'b1) begin
      failures++; $display("FAIL pseudo_b pc=%h tk=%b want a0000100/1", pc_out, taken);
    end
    checks++;
    step(0, 1, 0, 4'd7, 0, 0, 32'hA000_0010, 3'b010, 1);
    op(4'd6, 0, 26'h40, 0);
    if (pc_out !== 32'hA000_0014 || taken !== 1'b0) begin
      failures++; $display("FAIL bncy_fall pc=%h tk=%b want a0000014/0", pc_out, taken);
    end
    checks++;
    op(4'd5, 0, 26'h40, 0);
    if (pc_out !== 32'hA000_0100 || taken !== 1'b1) begin
      failures++; $display("FAIL bcy_taken pc=%h tk=%b want a0000100/1", pc_out, taken);
    end
    checks++;
  endtask

  task automatic test_call_ret;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    op(4'd7, 0, 0, 32'h300);
    op(4'd8, 0, 26'h100, 0);
    if (pc_out !== 32'h400 || link_out !== 32'h304 || taken !== 1'b1) begin
      failures++; $display("FAIL bl pc=%h link=%h tk=%b want 400/304/1", pc_out, link_out, taken);
    end
    checks++;
    op(4'd9, 0, 0, 0);
    if (pc_out !== 32'h304 || taken !== 1'b1 || ras_underflow !== 1'b0) begin
      failures++; $display("FAIL ret pc=%h tk=%b un=%b want 304/1/0", pc_out, taken, ras_underflow);
    end
    checks++;
    op(4'd9, 0, 0, 0);
    if (pc_out !== 32'h308 || taken !== 1'b0 || ras_underflow !== 1'b1) begin
      failures++; $display("FAIL ret_empty pc=%h tk=%b un=%b want 308/0/1", pc_out, taken, ras_underflow);
    end
    checks++;
  endtask

  task automatic test_ras_bounds;
    logic [31:0] want;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    op(4'd7, 0, 0, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      op(4'd8, 0, 26'((32'h2000 + 32'(i) * 32'h100) >> 2), 0);
      if (ras_overflow !== (i == 4) || pc_out !== 32'h2000 + 32'(i) * 32'h100) begin
        failures++; $display("FAIL bl_nest%0d ov=%b pc=%h", i, ras_overflow, pc_out);
      end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      op(4'd9, 0, 0, 0);
      want = 32'h2304 - 32'(i) * 32'h100;
      if (pc_out !== want || taken !== 1'b1 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
        failures++; $display("FAIL ret_nest%0d pc=%h tk=%b ov=%b want %h", i, pc_out, taken, ras_overflow, want);
      end
      checks++;
    end
    op(4'd9, 0, 0, 0);
    if (pc_out !== 32'h2008 || taken !== 1'b0 || ras_underflow !== 1'b1) begin
      failures++; $display("FAIL ret_under pc=%h tk=%b un=%b want 2008/0/1", pc_out, taken, ras_underflow);
    end
    checks++;
    op(4'd0, 0, 0, 0);
    if (ras_underflow !== 1'b0) begin
      failures++; $display("FAIL under_pulse un=%b want 0", ras_underflow);
    end
    checks++;
  endtask

  task automatic test_stall_reset;
    logic [31:0] held;
    held = pc_out;
    step(0, 1, 1, 4'd7, 0, 0, 32'h800, 3'b111, 1);
    if (pc_out !== held || taken !== 1'b0) begin
      failures++; $display("FAIL stall_hold pc=%h tk=%b want %h/0", pc_out, taken, held);
    end
    checks++;
    op(4'd3, 32'h10, 0, 0);
    if (pc_out !== held + 32'd4) begin
      failures++; $display("FAIL stall_flags pc=%h want %h", pc_out, held + 32'd4);
    end
    checks++;
    step(1, 1, 0, 4'd7, 0, 0, 32'h800, 0, 0);
    if (pc_out !== 32'h100 || taken !== 1'b0) begin
      failures++; $display("FAIL rst_priority pc=%h tk=%b want 100/0", pc_out, taken);
    end
    checks++;
  endtask

  task automatic test_random;
    logic [31:0] im;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      im = ($urandom % 2) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      step($urandom % 64 == 0, $urandom % 4 != 0, $urandom % 5 == 0, 4'($urandom_range(0, 15)),
           im, 26'($urandom), $urandom & 32'hFFFF_FFFC, 3'($urandom), $urandom % 3 == 0);
      if ({pc_out, link_out, taken, ras_overflow, ras_underflow} !== {m_pc, m_link, m_tk, m_ov, m_un}) begin
        failures++;
        $display("FAIL random%0d pc=%h link=%h tk=%b ov=%b un=%b want pc=%h link=%h tk=%b ov=%b un=%b",
                 i, pc_out, link_out, taken, ras_overflow, ras_underflow, m_pc, m_link, m_tk, m_ov, m_un);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1; stall = 0; instr_valid = 0; flags_we = 0; br_type = 0;
    imm = 0; reg_target = 0; pseudo_addr = 0; flags_in = 0;
    test_reset;
    test_cond;
    test_pseudo;
    test_call_ret;
    test_ras_bounds;
    test_stall_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
